instr_mem_controller: RTL

INSTR_MEM_CONTROLLER -- requirements
Module: instr_mem_controller

---
 rtl/instr_mem_controller.sv | 125 ++++++++++++
 1 files changed

// File: rtl/instr_mem_controller.sv
// Instruction-memory controller: NUM_CHANNELS independent channels serving NUM_CONSUMERS fetchers.
// Optional macro IMC_ROUND_ROBIN_EN selects a round-robin claim scan; the default is fixed priority.
//   state    | meaning
//   IDLE     | channel free, claims one eligible consumer
//   WAITING  | memory request outstanding, address held stable
//   RELAYING | response delivered, ownership kept until the consumer drops valid
module instr_mem_controller #(
   parameter int NUM_CONSUMERS = 4,
   parameter int NUM_CHANNELS  = 1,
   parameter int ADDR_WIDTH    = 16,
   parameter int DATA_WIDTH    = 16
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic [NUM_CONSUMERS-1:0]                    consumer_read_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0]    consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]                    consumer_read_ready,
   output logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0]    consumer_read_data,
   output logic [NUM_CHANNELS-1:0]                     mem_read_valid,
   output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]     mem_read_address,
   input  logic [NUM_CHANNELS-1:0]                     mem_read_ready,
   input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]     mem_read_data
);

   localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [1:0] {IDLE, WAITING, RELAYING} state_t;

   state_t                       state [NUM_CHANNELS];
   logic [IDX_W-1:0]             owner [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]      claim_hit;
   logic [IDX_W-1:0]             claim_idx [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0]     taken;
   logic                         grant_any;
   logic [IDX_W-1:0]             grant_last;

`ifdef IMC_ROUND_ROBIN_EN
   logic [IDX_W-1:0]             rr_ptr;
`endif

   // Busy channels mask their owners first; idle channels then claim in index order
   // so a lower channel always wins a consumer both could see.
   always_comb begin
      int cand;
      taken      = '0;
      claim_hit  = '0;
      grant_any  = 1'b0;
      grant_last = '0;
      cand       = 0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         claim_idx[ch] = '0;
         if (state[ch] != IDLE)
            taken[owner[ch]] = 1'b1;
      end
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         if (state[ch] == IDLE) begin
            for (int k = 0; k < NUM_CONSUMERS; k++) begin
`ifdef IMC_ROUND_ROBIN_EN
               cand = (int'(rr_ptr) + 1 + k) % NUM_CONSUMERS;
`else
               cand = k;
`endif
               if (!claim_hit[ch] && consumer_read_valid[cand] && !taken[cand]) begin
                  claim_hit[ch] = 1'b1;
                  claim_idx[ch] = IDX_W'(cand);
               end
            end
         end
         if (claim_hit[ch]) begin
            taken[claim_idx[ch]] = 1'b1;
            grant_any            = 1'b1;
            grant_last           = claim_idx[ch];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state[ch] <= IDLE;
            owner[ch] <= '0;
         end
         mem_read_valid      <= '0;
         mem_read_address    <= '0;
         consumer_read_ready <= '0;
         consumer_read_data  <= '0;
`ifdef IMC_ROUND_ROBIN_EN
         rr_ptr              <= '0;
`endif
      end else begin
         consumer_read_ready <= '0;
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state[ch])
               IDLE: begin
                  if (claim_hit[ch]) begin
                     owner[ch]            <= claim_idx[ch];
                     mem_read_address[ch] <= consumer_read_address[claim_idx[ch]];
                     mem_read_valid[ch]   <= 1'b1;
                     state[ch]            <= WAITING;
                  end
               end
               WAITING: begin
                  // The response is relayed even if the consumer has since dropped valid.
                  if (mem_read_ready[ch]) begin
                     mem_read_valid[ch]               <= 1'b0;
                     consumer_read_ready[owner[ch]]   <= 1'b1;
                     consumer_read_data[owner[ch]]    <= mem_read_data[ch];
                     state[ch]                        <= RELAYING;
                  end
               end
               RELAYING: begin
                  if (!consumer_read_valid[owner[ch]])
                     state[ch] <= IDLE;
               end
               default: state[ch] <= IDLE;
            endcase
         end
`ifdef IMC_ROUND_ROBIN_EN
         if (grant_any)
            rr_ptr <= grant_last;
`endif
      end
   end

endmodule
